// File: rtl/tdm_demux_4ch_pkg.sv
// rtl/tdm_demux_4ch_pkg.sv - shared types and constants for the 4-channel TDM demultiplexer
package tdm_demux_4ch_pkg;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam int NUM_CH = 4;
   localparam int SLOT_W = 2;

endpackage

// File: rtl/tdm_bit_counter.sv
// rtl/tdm_bit_counter.sv - WIDTH-modulo bit counter with enable, synchronous clear and wrap flag
module tdm_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o,
   output logic             wrap_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign wrap_o  = en_i && !clr_i && (count_q == CNT_W'(WIDTH - 1));
   assign count_o = count_q;

   // Clear together with enable counts the clearing sample as bit 0, so the result is 1.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = en_i ? CNT_W'(1) : '0;
      end else if (en_i) begin
         count_d = wrap_o ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tdm_demux_4ch.sv
// rtl/tdm_demux_4ch.sv - serial 4-slot TDM frame demultiplexer with frame-sync lock tracking
module tdm_demux_4ch
   import tdm_demux_4ch_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic [3:0]       ch_valid,
   output logic             locked,
   output logic             sync_err
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   shreg_q;
   logic [SLOT_W-1:0]  slot_q;
   logic [WIDTH-1:0]   ch_q [NUM_CH];
   logic [NUM_CH-1:0]  ch_valid_q;
   logic               sync_err_q;

   logic [CNT_W-1:0]   bit_cnt;
   logic               bit_wrap;
   logic               cnt_en;
   logic               cnt_clr;
   logic               realign;
   logic               shift_en;
   logic               frame_err;
   logic               at_frame_start;
   logic [WIDTH-1:0]   word_d;

   tdm_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk     (clk),
      .reset   (reset),
      .en_i    (cnt_en),
      .clr_i   (cnt_clr),
      .count_o (bit_cnt),
      .wrap_o  (bit_wrap)
   );

   assign at_frame_start = (bit_cnt == '0) && (slot_q == '0);
   assign word_d         = {shreg_q[WIDTH-2:0], din};

   always_comb begin
      state_d   = state_q;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      realign   = 1'b0;
      shift_en  = 1'b0;
      frame_err = 1'b0;
      if (din_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (frame_sync) begin
                  state_d = ST_LOCKED;
                  realign = 1'b1;
                  cnt_clr = 1'b1;
                  cnt_en  = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (at_frame_start && !frame_sync) begin
                  // Missing sync: the offending bit is dropped and we hunt again.
                  state_d   = ST_HUNT;
                  frame_err = 1'b1;
                  cnt_clr   = 1'b1;
               end else if (!at_frame_start && frame_sync) begin
                  // Misplaced sync: abandon the partial word, restart at slot 0 bit 0.
                  frame_err = 1'b1;
                  realign   = 1'b1;
                  cnt_clr   = 1'b1;
                  cnt_en    = 1'b1;
               end else begin
                  shift_en = 1'b1;
                  cnt_en   = 1'b1;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_HUNT;
         shreg_q    <= '0;
         slot_q     <= '0;
         ch_valid_q <= '0;
         sync_err_q <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            ch_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ch_valid_q <= '0;
         sync_err_q <= frame_err;
         if (realign) begin
            shreg_q <= {{(WIDTH-1){1'b0}}, din};
            slot_q  <= '0;
         end else if (shift_en) begin
            shreg_q <= word_d;
            if (bit_wrap) begin
               ch_q[slot_q]       <= word_d;
               ch_valid_q[slot_q] <= 1'b1;
               slot_q             <= slot_q + 1'b1;
            end
         end else if (frame_err) begin
            shreg_q <= '0;
            slot_q  <= '0;
         end
      end
   end

   assign ch0      = ch_q[0];
   assign ch1      = ch_q[1];
   assign ch2      = ch_q[2];
   assign ch3      = ch_q[3];
   assign ch_valid = ch_valid_q;
   assign locked   = (state_q == ST_LOCKED);
   assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb/tb_tdm_demux_4ch.sv - self-checking bench for tdm_demux_4ch against a frame-position model
module tb_tdm_demux_4ch;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         din = 1'b0;
   logic         din_valid = 1'b0;
   logic         frame_sync = 1'b0;
   logic [W-1:0] ch0, ch1, ch2, ch3;
   logic [3:0]   ch_valid;
   logic         locked;
   logic         sync_err;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // Reference model: lock flag, position inside the 4*W-bit frame, bit accumulator.
   bit           m_locked;
   int           m_pos;
   logic [15:0]  m_acc;
   logic [W-1:0] m_ch [4];
   logic [3:0]   m_cv;
   logic         m_err;

   always #5 clk = ~clk;

   tdm_demux_4ch #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .ch0        (ch0),
      .ch1        (ch1),
      .ch2        (ch2),
      .ch3        (ch3),
      .ch_valid   (ch_valid),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic v, input logic fs, input logic d);
      m_cv  = '0;
      m_err = 1'b0;
      if (r) begin
         m_locked = 1'b0;
         m_pos    = 0;
         m_acc    = '0;
         for (int k = 0; k < 4; k++) m_ch[k] = '0;
      end else if (v) begin
         if (!m_locked) begin
            if (fs) begin
               m_locked = 1'b1;
               m_pos    = 1;
               m_acc    = {15'b0, d};
            end
         end else if (m_pos == 0 && !fs) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
         end else if (m_pos != 0 && fs) begin
            m_err = 1'b1;
            m_pos = 1;
            m_acc = {15'b0, d};
         end else begin
            m_acc = {m_acc[14:0], d};
            m_pos++;
            if (m_pos % W == 0) begin
               m_ch[m_pos / W - 1] = m_acc[W-1:0];
               m_cv[m_pos / W - 1] = 1'b1;
            end
            if (m_pos == 4 * W) m_pos = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("ch_valid", {28'b0, ch_valid}, {28'b0, m_cv});
      check("locked", {31'b0, locked}, {31'b0, m_locked});
      check("sync_err", {31'b0, sync_err}, {31'b0, m_err});
      check("ch0", {24'b0, ch0}, {24'b0, m_ch[0]});
      check("ch1", {24'b0, ch1}, {24'b0, m_ch[1]});
      check("ch2", {24'b0, ch2}, {24'b0, m_ch[2]});
      check("ch3", {24'b0, ch3}, {24'b0, m_ch[3]});
   endtask

   task automatic step(input logic r, input logic v, input logic fs, input logic d);
      reset      = r;
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      @(posedge clk);
      model_update(r, v, fs, d);
      #1;
      compare_all();
   endtask

   task automatic idle_gap(input int n);
      for (int g = 0; g < n; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic send_bits(input logic [31:0] f, input int first, input int last, input bit sync_first,
                            input int stray, input int gap_every, input bit rgap);
      for (int i = first; i < last; i++) begin
         step(1'b0, 1'b1, 1'((i == 0 && sync_first) || (i == stray)), f[31-i]);
         if (gap_every > 0 && (i % gap_every) == gap_every - 1) idle_gap(3);
         if (rgap) idle_gap($urandom_range(0, 2));
      end
   endtask

   task automatic check_words(input string tag, input logic [31:0] f);
      check({tag, "_ch0"}, {24'b0, ch0}, {24'b0, f[31:24]});
      check({tag, "_ch1"}, {24'b0, ch1}, {24'b0, f[23:16]});
      check({tag, "_ch2"}, {24'b0, ch2}, {24'b0, f[15:8]});
      check({tag, "_ch3"}, {24'b0, ch3}, {24'b0, f[7:0]});
   endtask

   initial begin
      logic [31:0] rf;
      int          mode;

      repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
      check_words("reset", 32'h0);
      check("reset_locked", {31'b0, locked}, 32'd0);
      check("reset_cv", {28'b0, ch_valid}, 32'd0);

      // Sync with din_valid low is ignored.
      repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1);
      check("idle_sync_locked", {31'b0, locked}, 32'd0);

      send_bits(32'hA53CFF01, 0, 32, 1'b1, -1, 0, 1'b0);
      check_words("basic", 32'hA53CFF01);
      check("basic_locked", {31'b0, locked}, 32'd1);

      send_bits(32'hA53CFF01, 0, 32, 1'b1, -1, 2, 1'b0);
      check_words("gapped", 32'hA53CFF01);

      send_bits(32'h11223344, 0, 32, 1'b1, -1, 0, 1'b0);
      send_bits(32'h55667788, 0, 32, 1'b0, -1, 0, 1'b0);
      check("nosync_locked", {31'b0, locked}, 32'd0);
      check_words("nosync", 32'h11223344);

      send_bits(32'h11223344, 0, 32, 1'b1, -1, 0, 1'b0);
      send_bits(32'hAABBCCDD, 0, 19, 1'b1, -1, 0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("realign_err", {31'b0, sync_err}, 32'd1);
      check("realign_ch2_held", {24'b0, ch2}, 32'h33);
      check("realign_ch1", {24'b0, ch1}, 32'hBB);
      send_bits(32'h92345678, 1, 32, 1'b1, -1, 0, 1'b0);
      check_words("realign", 32'h92345678);
      check("realign_locked", {31'b0, locked}, 32'd1);

      send_bits(32'hDEADBEEF, 0, 13, 1'b1, -1, 0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check_words("midreset", 32'h0);
      check("midreset_cv", {28'b0, ch_valid}, 32'd0);
      check("midreset_err", {31'b0, sync_err}, 32'd0);
      check("midreset_locked", {31'b0, locked}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      send_bits(32'hC0FFEE42, 0, 32, 1'b1, -1, 0, 1'b0);
      check_words("postreset", 32'hC0FFEE42);

      for (int n = 0; n < 16; n++) begin
         rf   = $urandom;
         mode = $urandom_range(0, 5);
         send_bits(rf, 0, 32, mode != 0, (mode == 1) ? $urandom_range(1, 31) : -1, 0, 1'b1);
      end
      send_bits(32'h0F1E2D3C, 0, 32, 1'b1, -1, 0, 1'b0);
      send_bits(32'h0F1E2D3C, 0, 32, 1'b1, -1, 0, 1'b1);
      check_words("final", 32'h0F1E2D3C);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
